// File: rtl/movavg_seq.sv
// Sequential moving-sum / moving-average: one adder folds the current sample and
// TAPS-1 history taps into an accumulator over TAPS cycles, then publishes sum and average.
module movavg_seq #(
  parameter  int WIDTH = 64,
  parameter  int TAPS  = 4,
  localparam int SW    = $clog2(TAPS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    din,
  input  logic                din_valid,
  output logic                read,
  input  logic                clear,
  output logic [WIDTH+SW-1:0] dout,
  output logic [WIDTH-1:0]    avg,
  output logic                dout_valid
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                         state_q;
  // tap_q[0] is the sample being summed; tap_q[1..TAPS-1] is history, [1] newest
  logic [TAPS-1:0][WIDTH-1:0]     tap_q;
  logic [WIDTH+SW-1:0]            acc_q, acc_d;
  logic [WIDTH+SW-1:0]            dout_q;
  logic [WIDTH-1:0]               avg_q;
  logic [SW-1:0]                  idx_q;
  logic                           read_q, dv_q;

  assign acc_d = acc_q + {{SW{1'b0}}, tap_q[idx_q]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tap_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      avg_q   <= '0;
      idx_q   <= '0;
      read_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      case (state_q)
        IDLE: begin
          read_q <= 1'b1;
          // clear wins over din_valid; the producer keeps din pending
          if (clear) begin
            for (int k = 1; k < TAPS; k++) tap_q[k] <= '0;
          end else if (read_q && din_valid) begin
            tap_q[0] <= din;
            acc_q    <= {{SW{1'b0}}, din};
            idx_q    <= SW'(1);
            read_q   <= 1'b0;
            state_q  <= ACCUM;
          end
        end
        ACCUM: begin
          acc_q <= acc_d;
          idx_q <= idx_q + SW'(1);
          if (idx_q == SW'(TAPS - 1)) state_q <= DONE;
        end
        DONE: begin
          dout_q <= acc_q;
          avg_q  <= acc_q[WIDTH+SW-1:SW];
          dv_q   <= 1'b1;
          for (int k = TAPS - 1; k > 0; k--) tap_q[k] <= tap_q[k-1];
          read_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read       = read_q;
  assign dout       = dout_q;
  assign avg        = avg_q;
  assign dout_valid = dv_q;

endmodule

// File: doc/movavg_seq.md
# movavg_seq

Parametrised sequential moving-sum / moving-average unit, successor to the fixed 4-tap, 64-bit moving average in the same datapath. It keeps a history of the last TAPS-1 accepted samples and, per new sample, accumulates sample plus history with one adder over TAPS cycles. It adds a valid/ready input handshake, a full-precision sum output, a truncating average output, and a synchronous history clear.

## Interface
- WIDTH, 64, sample width in bits (>= 8)
- TAPS, 4, window length including current sample; power of two, 2..64
- SW, $clog2(TAPS), derived local parameter; not overridable

- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- din  input  WIDTH  unsigned sample
- din_valid  input  1  din presented this cycle
- read  output  1  block ready to accept; sample accepted on a rising edge with read & din_valid
- clear  input  1  synchronous: zero history (only acted on in IDLE)
- dout  output  WIDTH+SW  full-precision sum of current sample and last TAPS-1 accepted samples
- avg  output  WIDTH  dout >> SW (truncating)
- dout_valid  output  1  one-cycle pulse: dout/avg updated

## Operation
- Storage: sample register, history taps tap[1..TAPS-1] (tap[1] newest), accumulator WIDTH+SW bits, index counter SW bits.
- States: IDLE, ACCUM, DONE.
- IDLE: read=1. If clear: all taps <= 0, no accept, stay IDLE (clear beats din_valid; producer holds din). Else if din_valid: sample <= din, acc <= zero-extended din, idx <= 1, -> ACCUM.
- ACCUM: read=0; acc <= acc + tap[idx]; idx++; after adding tap[TAPS-1] -> DONE.
- DONE: read=0; dout <= acc, avg <= acc[WIDTH+SW-1:SW], dout_valid=1 this cycle only; taps shift (tap[k] <= tap[k-1], tap[1] <= sample); -> IDLE.
- din_valid and clear ignored outside IDLE.
- Arithmetic unsigned; WIDTH+SW accumulator cannot overflow; avg truncates toward zero.
- History is zero after reset, so first TAPS-1 outputs sum fewer real samples (no warm-up masking).

## Timing
- Reset (reset=0, async): state IDLE, read=0, dout=0, avg=0, dout_valid=0, taps/acc/sample=0.
- read is registered: rises on first rising edge after reset deasserts; no accept possible before that edge.
- Accept at edge k -> dout_valid=1 and new dout/avg visible after edge k+TAPS; read=1 again after edge k+TAPS; earliest next accept edge k+TAPS+1. Throughput one sample per TAPS+1 cycles (5 at TAPS=4).
- dout/avg hold between updates; dout_valid high exactly one cycle per accepted sample.
- Reset asserted mid-ACCUM/DONE: operation aborted, no dout_valid, history zeroed.
- clear in IDLE takes effect at that edge; next accepted sample sees zero history.

## Test plan
- Reset release, din_valid=1 held: read=0 until first edge, accept on second edge; dout_valid after TAPS more edges; no accept while read=0.
- TAPS=4, WIDTH=64, samples 1,2,3,4,5: dout = 1,3,6,10,14; avg = 0,0,1,2,3; dout_valid spacing 5 cycles.
- Overflow width: four samples 0xFFFF_FFFF_FFFF_FFFF: fourth dout = 0x3_FFFF_FFFF_FFFF_FFFC, avg = 0xFFFF_FFFF_FFFF_FFFF.
- Clear: samples 10,20,30, then clear with din_valid=1 for one IDLE cycle, then 7: clear cycle not accepted, next dout = 7.
- Reset mid-ACCUM after samples 5,6 and accept of 9: no dout_valid, dout=0; after restart sample 4 -> dout=4.
- Random: 200 random 64-bit samples at TAPS=4 and TAPS=8/WIDTH=32, compared against reference sum with exact TAPS+1 spacing.
